// File: rtl/ifft_pkg.sv
// Shared constants and FSM state type for the 4-point sequential IFFT.
package ifft_pkg;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/ifft_radix2_stage.sv
// Combinational radix-2 butterfly: sum = a+b, dif = a-b, optionally rotated by +j.
// Output is one bit wider than the input so no butterfly can overflow.
module ifft_radix2_stage
  import ifft_pkg::*;
#(
  parameter int W     = 32,
  parameter bit ROT_J = 1'b0
) (
  input  logic signed [W-1:0] i_a_re,
  input  logic signed [W-1:0] i_a_im,
  input  logic signed [W-1:0] i_b_re,
  input  logic signed [W-1:0] i_b_im,
  output logic signed [W:0]   o_sum_re,
  output logic signed [W:0]   o_sum_im,
  output logic signed [W:0]   o_dif_re,
  output logic signed [W:0]   o_dif_im
);

  logic signed [W:0] w_ar, w_ai, w_br, w_bi;
  logic signed [W:0] w_dr, w_di;

  assign w_ar = {i_a_re[W-1], i_a_re};
  assign w_ai = {i_a_im[W-1], i_a_im};
  assign w_br = {i_b_re[W-1], i_b_re};
  assign w_bi = {i_b_im[W-1], i_b_im};

  assign o_sum_re = w_ar + w_br;
  assign o_sum_im = w_ai + w_bi;
  assign w_dr     = w_ar - w_br;
  assign w_di     = w_ai - w_bi;

  // j(a+jb) = -b + ja; a difference never reaches -2^W, so the negate is safe
  generate
    if (ROT_J) begin : g_rot
      assign o_dif_re = -w_di;
      assign o_dif_im = w_dr;
    end else begin : g_pass
      assign o_dif_re = w_dr;
      assign o_dif_im = w_di;
    end
  endgenerate

endmodule

// File: rtl/ifft_4_point_seq.sv
// Sequential 4-point IFFT: collect 4 bins, compute in one cycle, emit 4 samples.
// Define IFFT_SCALE_EN to apply 1/N scaling (arithmetic >>> 2) before truncation.
module ifft_4_point_seq
  import ifft_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_last
);

  state_t                    r_state;
  logic [1:0]                r_cnt;
  logic [1:0]                r_ocnt;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic [DATA_W-1:0]         r_out_re;
  logic [DATA_W-1:0]         r_out_im;
  logic signed [DATA_W-1:0]  r_bin_re [4];
  logic signed [DATA_W-1:0]  r_bin_im [4];
  logic [DATA_W-1:0]         r_res_re [1:3];
  logic [DATA_W-1:0]         r_res_im [1:3];

  logic signed [DATA_W:0]    w_s02_re, w_s02_im, w_d02_re, w_d02_im;
  logic signed [DATA_W:0]    w_s13_re, w_s13_im, w_jd13_re, w_jd13_im;
  logic signed [DATA_W+1:0]  w_x_re [4];
  logic signed [DATA_W+1:0]  w_x_im [4];
  logic [DATA_W-1:0]         w_res_re [4];
  logic [DATA_W-1:0]         w_res_im [4];
  logic                      w_in_xfer;

  assign w_in_xfer = (r_state == COLLECT) && in_valid && r_in_ready;

  // First stage: even pair (X0,X2), odd pair (X1,X3) with +j on the odd difference
  ifft_radix2_stage #(.W(DATA_W), .ROT_J(1'b0)) u_s1_even (
    .i_a_re  (r_bin_re[0]), .i_a_im  (r_bin_im[0]),
    .i_b_re  (r_bin_re[2]), .i_b_im  (r_bin_im[2]),
    .o_sum_re(w_s02_re),    .o_sum_im(w_s02_im),
    .o_dif_re(w_d02_re),    .o_dif_im(w_d02_im)
  );

  ifft_radix2_stage #(.W(DATA_W), .ROT_J(1'b1)) u_s1_odd (
    .i_a_re  (r_bin_re[1]), .i_a_im  (r_bin_im[1]),
    .i_b_re  (r_bin_re[3]), .i_b_im  (r_bin_im[3]),
    .o_sum_re(w_s13_re),    .o_sum_im(w_s13_im),
    .o_dif_re(w_jd13_re),   .o_dif_im(w_jd13_im)
  );

  ifft_radix2_stage #(.W(DATA_W+1), .ROT_J(1'b0)) u_s2_sum (
    .i_a_re  (w_s02_re),  .i_a_im  (w_s02_im),
    .i_b_re  (w_s13_re),  .i_b_im  (w_s13_im),
    .o_sum_re(w_x_re[0]), .o_sum_im(w_x_im[0]),
    .o_dif_re(w_x_re[2]), .o_dif_im(w_x_im[2])
  );

  ifft_radix2_stage #(.W(DATA_W+1), .ROT_J(1'b0)) u_s2_dif (
    .i_a_re  (w_d02_re),  .i_a_im  (w_d02_im),
    .i_b_re  (w_jd13_re), .i_b_im  (w_jd13_im),
    .o_sum_re(w_x_re[1]), .o_sum_im(w_x_im[1]),
    .o_dif_re(w_x_re[3]), .o_dif_im(w_x_im[3])
  );

  generate
    for (genvar i = 0; i < 4; i++) begin : g_post
`ifdef IFFT_SCALE_EN
      assign w_res_re[i] = DATA_W'(w_x_re[i] >>> 2);
      assign w_res_im[i] = DATA_W'(w_x_im[i] >>> 2);
`else
      assign w_res_re[i] = DATA_W'(w_x_re[i]);
      assign w_res_im[i] = DATA_W'(w_x_im[i]);
`endif
    end
  endgenerate

  // Datapath storage needs no reset; a reset clears the counters that index it
  always_ff @(posedge clk) begin
    if (!rst && w_in_xfer) begin
      r_bin_re[r_cnt] <= in_real;
      r_bin_im[r_cnt] <= in_imag;
    end
    if (!rst && r_state == COMPUTE) begin
      for (int i = 1; i < 4; i++) begin
        r_res_re[i] <= w_res_re[i];
        r_res_im[i] <= w_res_im[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_cnt       <= 2'd0;
      r_ocnt      <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_in_xfer) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state    <= COMPUTE;
              r_in_ready <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          r_state     <= EMIT;
          r_ocnt      <= 2'd0;
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          r_out_re    <= w_res_re[0];
          r_out_im    <= w_res_im[0];
        end
        EMIT: begin
          if (out_ready) begin
            if (r_ocnt == 2'd3) begin
              r_state     <= COLLECT;
              r_ocnt      <= 2'd0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_ocnt     <= r_ocnt + 2'd1;
              r_out_re   <= r_res_re[r_ocnt + 2'd1];
              r_out_im   <= r_res_im[r_ocnt + 2'd1];
              r_out_last <= (r_ocnt == 2'd2);
            end
          end
        end
        default: begin
          r_state    <= COLLECT;
          r_cnt      <= 2'd0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_real  = r_out_re;
  assign out_imag  = r_out_im;

endmodule

// File: tb/tb_ifft_4_point_seq.sv
// Scoreboard bench for ifft_4_point_seq; reference is a direct 4-point inverse DFT.
module tb_ifft_4_point_seq;
  import ifft_pkg::*;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_real = '0;
  logic [31:0] in_imag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_real;
  logic [31:0] out_imag;
  logic        out_last;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  ifft_4_point_seq #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  // Every output transfer is checked against the oldest expected sample
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got re=%h im=%h last=%b with nothing expected",
                 out_real, out_imag, out_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({out_real, out_imag, out_last} !== {e.re, e.im, e.last}) begin
          failures++;
          $display("FAIL sample: got re=%h im=%h last=%b, expected re=%h im=%h last=%b",
                   out_real, out_imag, out_last, e.re, e.im, e.last);
        end
      end
    end
  end

  // x[n] = sum_k X[k] * j^(n*k), then optional /4 and wrap to 32 bits
  function automatic void push_expect(input logic [31:0] re[4], input logic [31:0] im[4]);
    for (int n = 0; n < 4; n++) begin
      longint sr, si, a, b;
      exp_t   e;
      sr = 0;
      si = 0;
      for (int k = 0; k < 4; k++) begin
        a = longint'($signed(re[k]));
        b = longint'($signed(im[k]));
        case ((n * k) % 4)
          0: begin sr += a; si += b; end
          1: begin sr -= b; si += a; end
          2: begin sr -= a; si -= b; end
          default: begin sr += b; si -= a; end
        endcase
      end
`ifdef IFFT_SCALE_EN
      sr = sr >>> 2;
      si = si >>> 2;
`endif
      e.re   = sr[31:0];
      e.im   = si[31:0];
      e.last = (n == 3);
      q.push_back(e);
    end
  endfunction

  task automatic send_bin(input logic [31:0] re, input logic [31:0] im);
    bit ok;
    ok = 1'b0;
    in_real  = re;
    in_imag  = im;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_bin_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic send_frame(input logic [31:0] re[4], input logic [31:0] im[4]);
    push_expect(re, im);
    for (int k = 0; k < 4; k++) send_bin(re[k], im[k]);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d, required 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
    checks++; if (out_real !== 32'h0) begin failures++; $display("FAIL reset_out_real: got %h, required 0", out_real); end
    checks++; if (out_imag !== 32'h0) begin failures++; $display("FAIL reset_out_imag: got %h, required 0", out_imag); end
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_impulse_latency();
    logic [31:0] re[4], im[4];
    re = '{ONE, ZERO, ZERO, ZERO};
    im = '{ZERO, ZERO, ZERO, ZERO};
    out_ready = 1'b1;
    send_frame(re, im);
    // one edge past bin 3: COMPUTE, nothing accepted or presented
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL compute_out_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL compute_in_ready: got %b, required 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_out_valid: got %b, required 1", out_valid); end
    drain();
  endtask

  task automatic test_single_bin();
    logic [31:0] re[4], im[4];
    re = '{ZERO, ONE, ZERO, ZERO};
    im = '{ZERO, ZERO, ZERO, ZERO};
    send_frame(re, im);
    drain();
    re = '{ZERO, ZERO, ZERO, ZERO};
    im = '{ZERO, ZERO, ZERO, ONE};
    send_frame(re, im);
    drain();
  endtask

  task automatic test_dc();
    logic [31:0] re[4], im[4], want;
    bit seen;
    re = '{ONE, ONE, ONE, ONE};
    im = '{ZERO, ZERO, ZERO, ZERO};
`ifdef IFFT_SCALE_EN
    want = 32'h0001_0000;
`else
    want = 32'h0004_0000;
`endif
    out_ready = 1'b0;
    send_frame(re, im);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || out_real !== want || out_imag !== 32'h0) begin
      failures++;
      $display("FAIL dc_x0: got valid=%b re=%h im=%h, required re=%h im=0", seen, out_real, out_imag, want);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] re[4], im[4];
    re = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    im = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    send_frame(re, im);
    drain();
    re = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    im = '{32'hFFFF_FFFD, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0001};
    send_frame(re, im);
    drain();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++) begin
        re[k] = $urandom;
        im[k] = $urandom;
      end
      send_frame(re, im);
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] re[4], im[4], held_re, held_im;
    bit seen;
    for (int k = 0; k < 4; k++) begin
      re[k] = $urandom;
      im[k] = $urandom;
    end
    out_ready = 1'b0;
    send_frame(re, im);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    held_re = out_real;
    held_im = out_imag;
    checks++;
    if (!seen || held_re !== q[0].re || held_im !== q[0].im) begin
      failures++;
      $display("FAIL bp_first: got valid=%b re=%h im=%h, required re=%h im=%h",
               seen, held_re, held_im, q[0].re, q[0].im);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_real !== held_re || out_imag !== held_im || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: got valid=%b re=%h im=%h in_ready=%b, required 1 %h %h 0",
                 out_valid, out_real, out_imag, in_ready, held_re, held_im);
      end
    end
    drain();
  endtask

  task automatic test_midframe_reset();
    logic [31:0] re[4], im[4];
    bit seen;
    out_ready = 1'b1;
    send_bin(32'h1234_5678, 32'h0000_1111);
    send_bin(32'h0BAD_F00D, 32'hFFFF_0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
    re = '{32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0003_0000};
    im = '{32'h0000_4000, 32'h0001_0000, 32'hFFFE_0000, 32'h0000_0000};
    send_frame(re, im);
    drain();
    // reset while a result is waiting on a stalled downstream
    out_ready = 1'b0;
    send_frame(re, im);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (!seen || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL emit_rst: got seen=%b out_valid=%b in_ready=%b, required 1 0 1", seen, out_valid, in_ready);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] bb_re[12], bb_im[12], fr[4], fi[4];
    int b, npush, cyc, lows, nr, tail;
    int rises[4];
    bit prev_ov, acc;
    for (int i = 0; i < 12; i++) begin
      bb_re[i] = $urandom;
      bb_im[i] = $urandom;
    end
    b = 0; npush = 0; cyc = 0; lows = 0; nr = 0; tail = 0; prev_ov = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 300 && tail < 2; t++) begin
      if (b < 12) begin
        if (b / 4 == npush) begin
          for (int k = 0; k < 4; k++) begin
            fr[k] = bb_re[npush*4+k];
            fi[k] = bb_im[npush*4+k];
          end
          push_expect(fr, fi);
          npush++;
        end
        in_valid = 1'b1;
        in_real  = bb_re[b];
        in_imag  = bb_im[b];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && !prev_ov && nr < 4) begin
        rises[nr] = cyc;
        nr++;
      end
      prev_ov = out_valid;
      if (!in_ready) lows++;
      acc = in_valid && in_ready;
      cyc++;
      @(posedge clk);
      #1;
      if (acc) b++;
      if (b == 12 && q.size() == 0) tail++;
    end
    in_valid = 1'b0;
    checks++;
    if (nr != 3) begin
      failures++;
      $display("FAIL b2b_frames: got %0d out_valid rises, required 3", nr);
    end else begin
      checks++;
      if (rises[1] - rises[0] != 9 || rises[2] - rises[1] != 9) begin
        failures++;
        $display("FAIL b2b_period: got %0d and %0d cycles, required 9", rises[1] - rises[0], rises[2] - rises[1]);
      end
    end
    checks++;
    if (lows != 15) begin
      failures++;
      $display("FAIL b2b_in_ready_low: got %0d cycles over 3 frames, required 15", lows);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL b2b_pending: got %0d samples outstanding, required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_impulse_latency();
    test_single_bin();
    test_dc();
    test_random();
    test_backpressure();
    test_midframe_reset();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
